// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: ALUOp and forward-select encodings, RISC-V opcodes.
// Latency: n/a (types, constants and one pure combinational helper).
// Backpressure: n/a.
package ctrl_pkg;

    // ALU operation class handed from decode to the ALU control decoder.
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_R_TYPE = 2'b10
    } alu_op_e;

    // EX operand source: register file read, WB-stage result or MEM-stage result.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

    // RV32I major opcodes, shared with control_unit so both decode the same way.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // The younger producer (MEM) always wins over the older one (WB).
    function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_REGFILE;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register: async clear, load-enable and synchronous bubble (zero) load.
// Latency: 1 cycle from d_i to q_o when en_i is high.
// Backpressure: en_i low holds the current contents; bubble_i has no effect while held.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next state: hold, load the incoming word, or load an all-zero bubble.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = bubble_i ? '0 : d_i;
        end
    end

    // State register; reset empties the stage immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control word pipeline ID->EX->MEM->WB with load-use stall and EX forwarding selects.
// Latency: ID word on ex_* after 1 edge, mem_* after 2, wb_* after 3 (edges with enable=1).
// Backpressure: enable=0 freezes every stage; stall holds PC/IF-ID and injects an EX bubble.
// Optional performance counters (stall_cnt, retired_cnt) exist only with CTRL_PIPE_PERF_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
`ifdef CTRL_PIPE_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  enable,

    input  logic                  id_valid,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_2_reg,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,

    output logic                  ex_valid,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_2_reg,
    output logic                  ex_reg_write,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,

    output logic                  mem_valid,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_2_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,

    output logic                  wb_valid,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,

    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      retired_cnt
`endif
);

    // Stage words. Each stage carries only what its consumers still need.
    typedef struct packed {
        logic                  valid;
        logic [1:0]            alu_op;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } ex_word_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } mem_word_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } wb_word_t;

    ex_word_t  ex_d,  ex_q;
    mem_word_t mem_d, mem_q;
    wb_word_t  wb_d,  wb_q;

    logic ex_bubble;
    logic hit_rs1;
    logic hit_rs2;
    logic mem_hit_a, mem_hit_b;
    logic wb_hit_a,  wb_hit_b;

    // Load-use hazard: the load in EX targets a register the ID instruction really reads.
    // x0 is excluded and a flushed ID slot never stalls.
    always_comb begin
        hit_rs1 = id_use_rs1 && (ex_q.rd == id_rs1);
        hit_rs2 = id_use_rs2 && (ex_q.rd == id_rs2);
        stall   = id_valid && ex_q.valid && ex_q.mem_read &&
                  (ex_q.rd != '0) && (hit_rs1 || hit_rs2);
    end

    // A stalled or flushed ID slot enters EX as an all-zero bubble, so no control bit
    // of an invalid instruction ever reaches MEM or WB.
    assign ex_bubble = stall || !id_valid;

    // Pack the decode word for EX.
    always_comb begin
        ex_d           = '0;
        ex_d.valid     = id_valid;
        ex_d.alu_op    = id_alu_op;
        ex_d.alu_src   = id_alu_src;
        ex_d.mem_read  = id_mem_read;
        ex_d.mem_write = id_mem_write;
        ex_d.mem_2_reg = id_mem_2_reg;
        ex_d.reg_write = id_reg_write;
        ex_d.rd        = id_rd;
        ex_d.rs1       = id_rs1;
        ex_d.rs2       = id_rs2;
    end

    // EX -> MEM and MEM -> WB carry the surviving fields forward unchanged.
    always_comb begin
        mem_d           = '0;
        mem_d.valid     = ex_q.valid;
        mem_d.mem_read  = ex_q.mem_read;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.mem_2_reg = ex_q.mem_2_reg;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.rd        = ex_q.rd;

        wb_d            = '0;
        wb_d.valid      = mem_q.valid;
        wb_d.mem_2_reg  = mem_q.mem_2_reg;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.rd         = mem_q.rd;
    end

    ctrl_stage_reg #(.W($bits(ex_word_t))) u_ex_reg (
        .clk      (clk),
        .arst     (arst),
        .en_i     (enable),
        .bubble_i (ex_bubble),
        .d_i      (ex_d),
        .q_o      (ex_q)
    );

    ctrl_stage_reg #(.W($bits(mem_word_t))) u_mem_reg (
        .clk      (clk),
        .arst     (arst),
        .en_i     (enable),
        .bubble_i (1'b0),
        .d_i      (mem_d),
        .q_o      (mem_q)
    );

    ctrl_stage_reg #(.W($bits(wb_word_t))) u_wb_reg (
        .clk      (clk),
        .arst     (arst),
        .en_i     (enable),
        .bubble_i (1'b0),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    // Forwarding: a valid register-writing producer in MEM or WB whose rd matches the
    // EX source. x0 is never forwarded because it is hard-wired to zero.
    always_comb begin
        mem_hit_a = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1);
        mem_hit_b = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2);
        wb_hit_a  = wb_q.valid  && wb_q.reg_write  && (wb_q.rd  != '0) && (wb_q.rd  == ex_q.rs1);
        wb_hit_b  = wb_q.valid  && wb_q.reg_write  && (wb_q.rd  != '0) && (wb_q.rd  == ex_q.rs2);
        fwd_a     = fwd_select(mem_hit_a, wb_hit_a);
        fwd_b     = fwd_select(mem_hit_b, wb_hit_b);
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_2_reg  = ex_q.mem_2_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;

    assign mem_valid     = mem_q.valid;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;
    assign mem_mem_2_reg = mem_q.mem_2_reg;
    assign mem_reg_write = mem_q.reg_write;
    assign mem_rd        = mem_q.rd;

    assign wb_valid      = wb_q.valid;
    assign wb_mem_2_reg  = wb_q.mem_2_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_rd         = wb_q.rd;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Counters advance only on edges where the pipeline itself advances; they wrap freely.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (enable && stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (enable && wb_q.valid) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared together with the pipeline.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: scoreboard of retiring WB words plus directed checks
// of stall, bubble, forwarding, flush, hold and reset behaviour.
// Counter checks are compiled in only with CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       enable = 1'b1;
    logic       id_valid = 1'b0;
    logic [1:0] id_alu_op = '0;
    logic       id_alu_src = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic       id_mem_2_reg = 1'b0, id_reg_write = 1'b0;
    logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;

    logic       ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd, ex_rs1, ex_rs2;
    logic       mem_valid, mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_mem_2_reg, wb_reg_write;
    logic [4:0] wb_rd;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt, retired_cnt;
`endif

    ctrl_pipe #(.REG_ADDR_W(5)) dut (
        .clk(clk), .arst(arst), .enable(enable),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_2_reg(id_mem_2_reg), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_2_reg(ex_mem_2_reg), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_2_reg(mem_mem_2_reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_mem_2_reg(wb_mem_2_reg), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [1:0] alu_op;
        logic       alu_src, mem_read, mem_write, mem_2_reg, reg_write;
        logic [4:0] rd, rs1, rs2;
        logic       use1, use2;
    } ins_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_2_reg;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic ins_t mk(input logic [1:0] op, input logic src, input logic mr,
                                input logic mw, input logic m2r, input logic rw,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2);
        ins_t i;
        i.vld = 1'b1; i.alu_op = op; i.alu_src = src; i.mem_read = mr; i.mem_write = mw;
        i.mem_2_reg = m2r; i.reg_write = rw; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.use1 = u1; i.use2 = u2;
        return i;
    endfunction

    function automatic ins_t f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return mk(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, rd, rs1, 5'd0, 1'b1, 1'b0);
    endfunction
    function automatic ins_t f_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return mk(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rd, rs1, 5'd0, 1'b1, 1'b0);
    endfunction
    function automatic ins_t f_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(ALU_R_TYPE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, rs1, rs2, 1'b1, 1'b1);
    endfunction
    function automatic ins_t f_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, rs1, rs2, 1'b1, 1'b1);
    endfunction

    task automatic drive(input ins_t i);
        id_valid = i.vld; id_alu_op = i.alu_op; id_alu_src = i.alu_src;
        id_mem_read = i.mem_read; id_mem_write = i.mem_write; id_mem_2_reg = i.mem_2_reg;
        id_reg_write = i.reg_write; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use_rs1 = i.use1; id_use_rs2 = i.use2;
    endtask

    // Entry/exit point of every task: 1 time unit after a rising edge.
    // Holds the word on ID until it is accepted; reports stall cycles and the EX valid
    // seen in the accepting cycle. ID is left empty on return.
    task automatic issue(input ins_t ins, output int stalls, output logic exv);
        ins_t nop;
        nop = '0;
        stalls = 0;
        exv = 1'b0;
        drive(ins);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exv = ex_valid;
            if (!stall) begin
                if (ins.vld && enable) sb.push_back({ins.rd, ins.reg_write, ins.mem_2_reg});
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (stalls >= 4) chk("stall_bound", 32'(stalls), 32'd1);
        @(posedge clk); #1;
        drive(nop);
    endtask

    task automatic idle(input int n);
        ins_t nop;
        nop = '0;
        drive(nop);
        enable = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input string tag);
        ins_t nop;
        nop = '0;
        drive(nop);
        arst = 1'b1;
        sb.delete();
        #1;
        chk({tag, "_ex_valid"},  32'(ex_valid),  32'd0);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
        chk({tag, "_ctrl"}, 32'({ex_alu_op, ex_reg_write, ex_mem_write, mem_reg_write,
                                   mem_mem_write, wb_reg_write}), 32'd0);
        chk({tag, "_rd"},   32'({ex_rd, mem_rd, wb_rd}), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_fwd"},   32'({fwd_a, fwd_b}), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk({tag, "_cnt"}, stall_cnt | retired_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    // Retirement monitor: every fresh valid WB word must match the oldest accepted ID word.
    initial begin
        logic fresh;
        sb_t  e;
        forever begin
            @(posedge clk);
            fresh = enable && !arst;
            @(negedge clk);
            if (fresh && !arst && wb_valid) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_rd), 32'h3f);
                end else begin
                    e = sb.pop_front();
                    chk("wb_rd",        32'(wb_rd),        32'(e.rd));
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
                    chk("wb_mem_2_reg", 32'(wb_mem_2_reg), 32'(e.mem_2_reg));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        logic exv;
        logic any_wr;
        ins_t t;

        @(posedge clk); #1;
        do_reset("rst0");

        // Mid-stream reset with three ALU_R instructions in flight.
        issue(f_r(5'd1, 5'd2, 5'd3), s, exv);
        issue(f_r(5'd2, 5'd3, 5'd4), s, exv);
        issue(f_r(5'd3, 5'd4, 5'd5), s, exv);
        do_reset("rst_mid");
        any_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); any_wr = any_wr | wb_reg_write | wb_valid;
            @(posedge clk); #1;
        end
        chk("rst_no_wb_write", 32'(any_wr), 32'd0);

        // Load-use: lw x5 ; add x6,x5,x7.
        issue(f_lw(5'd5, 5'd10), s, exv);
        chk("lu_lw_nostall", 32'(s), 32'd0);
        issue(f_r(5'd6, 5'd5, 5'd7), s, exv);
        chk("lu_stall_cycles", 32'(s), 32'd1);
        chk("lu_bubble_ex_valid", 32'(exv), 32'd0);
        @(negedge clk);
        chk("lu_fwd_a", 32'(fwd_a), 32'(FWD_WB));
        chk("lu_fwd_b", 32'(fwd_b), 32'(FWD_REGFILE));
        chk("lu_ex_rd", 32'(ex_rd), 32'd6);
        @(posedge clk); #1;

        // Flushed consumer of a load never stalls.
        issue(f_lw(5'd5, 5'd1), s, exv);
        t = f_r(5'd6, 5'd5, 5'd5); t.vld = 1'b0;
        issue(t, s, exv);
        chk("flushed_no_stall", 32'(s), 32'd0);

        // rs2 matches the load but is not actually read.
        issue(f_lw(5'd5, 5'd1), s, exv);
        t = f_addi(5'd6, 5'd1); t.rs2 = 5'd5;
        issue(t, s, exv);
        chk("unused_rs2_no_stall", 32'(s), 32'd0);

        // Back-to-back loads, each feeding the next instruction.
        issue(f_lw(5'd5, 5'd1), s, exv);
        issue(f_lw(5'd6, 5'd5), s, exv);
        chk("b2b_stall1", 32'(s), 32'd1);
        issue(f_r(5'd7, 5'd6, 5'd0), s, exv);
        chk("b2b_stall2", 32'(s), 32'd1);

        // addi x3 ; sub x4,x3,x3 -> both operands from MEM.
        issue(f_addi(5'd3, 5'd0), s, exv);
        issue(f_r(5'd4, 5'd3, 5'd3), s, exv);
        chk("sub_no_stall", 32'(s), 32'd0);
        @(negedge clk);
        chk("sub_fwd_a", 32'(fwd_a), 32'(FWD_MEM));
        chk("sub_fwd_b", 32'(fwd_b), 32'(FWD_MEM));
        chk("sub_ex_alu_op", 32'(ex_alu_op), 32'(ALU_R_TYPE));
        chk("sub_ex_rd", 32'(ex_rd), 32'd4);
        @(posedge clk); #1;

        // addi x3 ; addi x3 ; add x8,x3,x0 -> MEM priority, x0 never forwarded.
        issue(f_addi(5'd3, 5'd0), s, exv);
        issue(f_addi(5'd3, 5'd3), s, exv);
        issue(f_r(5'd8, 5'd3, 5'd0), s, exv);
        @(negedge clk);
        chk("prio_fwd_a", 32'(fwd_a), 32'(FWD_MEM));
        chk("prio_fwd_b", 32'(fwd_b), 32'(FWD_REGFILE));
        @(posedge clk); #1;

        // lw x0 ; add x9,x0,x0 -> no hazard and no forward on x0.
        issue(f_lw(5'd0, 5'd1), s, exv);
        issue(f_r(5'd9, 5'd0, 5'd0), s, exv);
        chk("x0_no_stall", 32'(s), 32'd0);
        @(negedge clk);
        chk("x0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        @(posedge clk); #1;

        // Flushed store, then two cycles with enable low.
        issue(f_addi(5'd11, 5'd1), s, exv);
        t = f_sw(5'd1, 5'd2); t.vld = 1'b0;
        issue(t, s, exv);
        @(negedge clk);
        chk("flush_ex_mem_write", 32'(ex_mem_write), 32'd0);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        enable = 1'b0;
        drive(f_r(5'd12, 5'd1, 5'd2));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_ex", 32'({ex_valid, ex_rd, ex_mem_write}), 32'd0);
            chk("hold_mem", 32'({mem_valid, mem_reg_write, mem_rd}), 32'({1'b1, 1'b1, 5'd11}));
            chk("hold_wb_valid", 32'(wb_valid), 32'd0);
        end
        enable = 1'b1;
        drive('0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_mem_mem_write", 32'(mem_mem_write), 32'd0);
        chk("flush_mem_valid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Ten ALU_I plus one load-use pair from a clean reset.
        do_reset("rst_perf");
        for (int k = 0; k < 10; k++) issue(f_addi(5'(k + 1), 5'd0), s, exv);
        issue(f_lw(5'd5, 5'd1), s, exv);
        issue(f_r(5'd6, 5'd5, 5'd7), s, exv);
        chk("perf_pair_stall", 32'(s), 32'd1);
        idle(6);
        chk("perf_sb_drained", 32'(sb.size()), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk("retired_cnt", retired_cnt, 32'd12);
        chk("stall_cnt", stall_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decode-stage control word from `control_unit` through the EX, MEM and WB pipeline registers of the 5-stage RISC-V core, with per-stage valid bits. Also owns load-use hazard detection, which inserts a bubble into EX and stalls PC and IF/ID. It produces the EX-stage forwarding selects. It sits directly downstream of `control_unit` and replaces the control fields of the ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register index width.
- `CNT_W`, 32: performance counter width. Used only with `CTRL_PIPE_PERF_EN`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `arst` in 1: asynchronous reset, active-high. Clears all state immediately.
- `enable` in 1: global pipeline advance. When low, all registers hold.
- `id_valid` in 1: the ID stage holds a real instruction. Low means IF/ID was flushed.
- `id_alu_op` in 2, `id_alu_src` in 1, `id_mem_read` in 1, `id_mem_write` in 1, `id_mem_2_reg` in 1, `id_reg_write` in 1: decode control word.
- `id_rd`, `id_rs1`, `id_rs2` in `REG_ADDR_W`: register indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `ex_valid`, `ex_alu_op`[2], `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_mem_2_reg`, `ex_reg_write`, `ex_rd`, `ex_rs1`, `ex_rs2` out: EX-stage control.
- `mem_valid`, `mem_mem_read`, `mem_mem_write`, `mem_mem_2_reg`, `mem_reg_write`, `mem_rd` out: MEM-stage control.
- `wb_valid`, `wb_mem_2_reg`, `wb_reg_write`, `wb_rd` out: WB-stage control.
- `stall` out 1: hold PC and IF/ID. Combinational.
- `fwd_a`, `fwd_b` out 2: EX operand source selects. Combinational from registered state.
- `stall_cnt`, `retired_cnt` out `CNT_W`: present only with `CTRL_PIPE_PERF_EN`.

## Operation
- Reset: every registered output is 0, including all valids, control bits, alu_op and rd fields. `stall` is 0, `fwd_a`/`fwd_b` are 2'b00, and counters are 0.
- Load-use hazard: `stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2))`.
- Advance when `enable=1`:
  - MEM takes the EX fields.
  - WB takes the MEM fields.
  - EX takes the ID fields with `ex_valid = id_valid`, unless `stall=1`. On a stall, EX takes a bubble: all control bits 0, alu_op 2'b00, indices 0, valid 0.
- A bubble in EX is also loaded whenever `id_valid=0`. The control bits are gated by valid, so a flushed instruction can never write memory or the register file downstream.
- Forwarding, evaluated identically for A (`ex_rs1`) and B (`ex_rs2`):
  - 2'b10 if `mem_valid & mem_reg_write & mem_rd != 0 & mem_rd == ex_rsN`.
  - Otherwise 2'b01 if `wb_valid & wb_reg_write & wb_rd != 0 & wb_rd == ex_rsN`.
  - Otherwise 2'b00.
  - MEM has priority over WB.
- x0 is never a hazard and never a forward source.
- `enable=0`: all stage registers and counters hold. `stall` and `fwd_*` still reflect current state.
- `arst` mid-operation: every stage is invalidated at once, and the in-flight instructions are discarded without side effects.

## Timing
- The ID word is visible on `ex_*` one cycle after the sampling edge, on `mem_*` after two cycles, and on `wb_*` after three.
- `stall` is asserted in the same cycle as the hazard. It lasts exactly one cycle per load-use pair, because the load leaves EX on the next edge.
- Back-to-back loads each feeding the next instruction produce one stall per pair.
- A stall coinciding with `id_valid=0` does not occur: the hazard term is gated by `id_valid`.

## Configuration
- `CTRL_PIPE_PERF_EN` defined:
  - `stall_cnt` increments on each edge where `enable & stall`.
  - `retired_cnt` increments on each edge where `enable & wb_valid`.
  - Both wrap modulo 2^`CNT_W` and are cleared by `arst`.
- `CTRL_PIPE_PERF_EN` undefined: both counters and their ports are absent, and the remaining behaviour is identical.

## Structure
- Shared package/header `ctrl_pkg` holds:
  - ALUOp encodings: ADD 2'b00, SUB 2'b01, R_TYPE 2'b10.
  - Forward select encodings: REGFILE 2'b00, WB 2'b01, MEM 2'b10.
  - The RISC-V opcode constants, which are shared with `control_unit`.
- One sub-module, `ctrl_stage_reg`: a parameterised-width register with async reset, enable and synchronous bubble-load. It is instantiated three times.

## Test plan
- Reset with `arst` pulsed mid-stream after 3 valid ALU_R instructions → all `*_valid`, `stall` and `fwd_*` are 0 within the reset cycle, and no `wb_reg_write` follows.
- `lw x5` then `add x6,x5,x7` (use_rs1, rs1=5) → `stall=1` for exactly one cycle, then `ex_valid=0` bubble. The add reaches EX with `fwd_a=2'b01` and `fwd_b=2'b00`.
- `addi x3` then `sub x4,x3,x3` → no stall. The sub in EX sees `fwd_a=fwd_b=2'b10`.
- `addi x3`, `addi x3`, `add x8,x3,x0` → `fwd_a=2'b10` (MEM priority) and `fwd_b=2'b00` (x0).
- `id_valid=0` for a STORE word → `ex_mem_write=0` and `ex_valid=0`, with no write reaching MEM. With `enable=0` for 2 cycles, all stage outputs hold.
- With `CTRL_PIPE_PERF_EN`, 10 ALU_I instructions plus 1 load-use pair → after drain, `retired_cnt=12` and `stall_cnt=1`.
